// File: rtl/madcap_pkt_pkg.sv
// Shared packet definitions for the MADCAP daisy-chain packet path.
// Field layout, packet types, odd-parity helper and router FSM states.
package madcap_pkt_pkg;

    typedef enum logic [1:0] {
        DATA   = 2'b00,
        TEST   = 2'b01,
        CFG_WR = 2'b10,
        CFG_RD = 2'b11
    } pkt_type_e;

    localparam int TYPE_LSB       = 0;
    localparam int TYPE_W         = 2;
    localparam int CHIP_ID_LSB    = 2;
    localparam int CHIP_ID_W      = 8;
    localparam int CFG_ADDR_LSB   = 10;
    localparam int CFG_ADDR_W     = 8;
    localparam int CFG_DATA_LSB   = 18;
    localparam int CFG_DATA_W     = 8;
    localparam int DOWNSTREAM_BIT = 62;
    localparam int PARITY_BIT     = 63;

    localparam logic [7:0] BROADCAST_ID = 8'hFF;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_CLEAR    = 3'd1;
    localparam state_t S_DISPATCH = 3'd2;
    localparam state_t S_READ     = 3'd3;
    localparam state_t S_SEND     = 3'd4;

    // Parity bit that makes the full 64-bit word carry an odd number of ones.
    function automatic logic odd_parity(input logic [62:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/uart_rx_pkt_router.sv
// Packet router behind uart_rx: unloads words, serves local config
// writes/reads and forwards everything else to a one-entry TX slot.
module uart_rx_pkt_router
    import madcap_pkt_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           chip_id,
    input  logic [WIDTH-2:0]     rx_data,
    input  logic                 rx_empty,
    input  logic                 parity_error,
    output logic                 uld_rx_data,
    output logic                 cfg_wr_en,
    output logic                 cfg_rd_en,
    output logic [ADDR_BITS-1:0] cfg_addr,
    output logic [DATA_BITS-1:0] cfg_wr_data,
    input  logic [DATA_BITS-1:0] cfg_rd_data,
    output logic [WIDTH-1:0]     tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           parity_err_cnt
);

    state_t           state;
    logic [WIDTH-2:0] pkt;
    logic             perr;

    logic [TYPE_W-1:0]    pkt_type;
    logic [CHIP_ID_W-1:0] pkt_chip;
    logic                 id_bcast;
    logic                 id_mine;
    logic                 is_wr;
    logic                 is_rd;
    logic                 d_perr;
    logic                 d_wr;
    logic                 d_rd;
    logic                 d_drop;
    logic                 d_fwd;
    logic [WIDTH-2:0]     reply;

    // Mutually exclusive dispatch decisions for the captured packet
    always_comb begin
        pkt_type = pkt[TYPE_LSB +: TYPE_W];
        pkt_chip = pkt[CHIP_ID_LSB +: CHIP_ID_W];
        id_bcast = (pkt_chip == BROADCAST_ID);
        id_mine  = (pkt_chip == chip_id);
        is_wr    = (pkt_type == CFG_WR);
        is_rd    = (pkt_type == CFG_RD);
        d_perr   = perr;
        d_wr     = !perr && is_wr && (id_mine || id_bcast);
        d_rd     = !perr && is_rd && id_mine;
        d_drop   = !perr && is_rd && id_bcast && !id_mine;
        d_fwd    = !perr && !(d_wr || d_rd || d_drop);
    end

    // Read reply: returned data, downstream marker, our own chip ID
    always_comb begin
        reply = pkt;
        reply[CFG_DATA_LSB +: DATA_BITS]   = cfg_rd_data;
        reply[DOWNSTREAM_BIT]              = 1'b1;
        reply[CHIP_ID_LSB +: CHIP_ID_W]    = chip_id;
    end

    // Router FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            pkt            <= '0;
            perr           <= 1'b0;
            uld_rx_data    <= 1'b0;
            cfg_wr_en      <= 1'b0;
            cfg_rd_en      <= 1'b0;
            cfg_addr       <= '0;
            cfg_wr_data    <= '0;
            tx_data        <= '0;
            tx_valid       <= 1'b0;
            parity_err_cnt <= '0;
        end else begin
            uld_rx_data <= 1'b0;
            cfg_wr_en   <= 1'b0;
            cfg_rd_en   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_empty) begin
                        pkt         <= rx_data;
                        perr        <= parity_error;
                        uld_rx_data <= 1'b1;
                        state       <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (rx_empty) begin
                        state <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    unique case (1'b1)
                        d_perr: begin
                            if (parity_err_cnt != 8'hFF) begin
                                parity_err_cnt <= parity_err_cnt + 8'd1;
                            end
                            state <= S_IDLE;
                        end
                        d_wr: begin
                            cfg_wr_en   <= 1'b1;
                            cfg_addr    <= pkt[CFG_ADDR_LSB +: ADDR_BITS];
                            cfg_wr_data <= pkt[CFG_DATA_LSB +: DATA_BITS];
                            if (id_bcast) begin
                                tx_data  <= {odd_parity(pkt), pkt};
                                tx_valid <= 1'b1;
                                state    <= S_SEND;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                        d_rd: begin
                            cfg_rd_en <= 1'b1;
                            cfg_addr  <= pkt[CFG_ADDR_LSB +: ADDR_BITS];
                            state     <= S_READ;
                        end
                        d_drop: begin
                            state <= S_IDLE;
                        end
                        d_fwd: begin
                            tx_data  <= {odd_parity(pkt), pkt};
                            tx_valid <= 1'b1;
                            state    <= S_SEND;
                        end
                        default: begin
                            state <= S_IDLE;
                        end
                    endcase
                end
                S_READ: begin
                    tx_data  <= {odd_parity(reply), reply};
                    tx_valid <= 1'b1;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_router.sv
// Self-checking bench for uart_rx_pkt_router: directed vector table,
// hand-written backpressure/parity/reset sequences, random scoreboard.
module tb_uart_rx_pkt_router;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  chip_id = 8'h05;
    logic [62:0] rx_data = '0;
    logic        parity_error = 1'b0;
    logic        rx_full = 1'b0;
    logic        rx_empty;
    logic        uld_rx_data;
    logic        cfg_wr_en;
    logic        cfg_rd_en;
    logic [7:0]  cfg_addr;
    logic [7:0]  cfg_wr_data;
    logic [7:0]  cfg_rd_data;
    logic [63:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  parity_err_cnt;

    logic rdy_man = 1'b0;
    logic rdy_rand = 1'b0;
    logic rand_mode = 1'b0;
    logic sb_on = 1'b0;

    assign rx_empty = ~rx_full;
    assign tx_ready = rand_mode ? rdy_rand : rdy_man;

    logic [7:0] mem [256];
    logic [7:0] mm  [256];
    assign cfg_rd_data = mem[cfg_addr];

    int cyc = 0;
    int load_edge = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_uld = 0;
    int n_wr = 0;
    int n_rd = 0;
    int n_txv = 0;
    int n_acc = 0;
    int pcnt_model = 0;

    typedef struct {
        logic [62:0] w;
        logic        pe;
    } rxw_t;

    typedef struct {
        logic [62:0] w;
        logic        pe;
        logic [7:0]  cid;
        logic        ewr;
        logic        erd;
        logic        etx;
        logic [7:0]  eaddr;
        logic [7:0]  ewd;
        logic [62:0] etx63;
    } vec_t;

    typedef struct {
        logic        wr;
        logic        rd;
        logic        tx;
        logic [7:0]  addr;
        logic [7:0]  wd;
        logic [63:0] txd;
    } pred_t;

    rxw_t        rxq[$];
    logic [15:0] exp_wr_q[$];
    logic [7:0]  exp_rd_q[$];
    logic [63:0] exp_tx_q[$];

    uart_rx_pkt_router dut (
        .clk            (clk),
        .reset          (reset),
        .chip_id        (chip_id),
        .rx_data        (rx_data),
        .rx_empty       (rx_empty),
        .parity_error   (parity_error),
        .uld_rx_data    (uld_rx_data),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_rd_en      (cfg_rd_en),
        .cfg_addr       (cfg_addr),
        .cfg_wr_data    (cfg_wr_data),
        .cfg_rd_data    (cfg_rd_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .parity_err_cnt (parity_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [62:0] mk(input logic [1:0] t, input logic [7:0] id,
                                       input logic [7:0] a, input logic [7:0] d,
                                       input logic [36:0] up);
        return {up, d, a, id, t};
    endfunction

    // Append a parity bit so the 64-bit word holds an odd count of ones
    function automatic logic [63:0] addpar(input logic [62:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < 63; i++) ones += int'(w[i]);
        return {((ones % 2) == 0), w};
    endfunction

    // Packet rules applied to a word; keeps the config mirror and error count
    function automatic pred_t predict(input logic [62:0] w, input logic pe, input logic [7:0] cid);
        pred_t p;
        logic [62:0] r;
        logic [1:0]  typ;
        logic [7:0]  id;
        p = '{1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 64'h0};
        typ = w[1:0];
        id = w[9:2];
        p.addr = w[17:10];
        p.wd = w[25:18];
        if (pe) begin
            if (pcnt_model < 255) pcnt_model++;
        end else if (typ == 2'b10 && (id == cid || id == 8'hFF)) begin
            p.wr = 1'b1;
            mm[p.addr] = p.wd;
            if (id == 8'hFF) begin
                p.tx = 1'b1;
                p.txd = addpar(w);
            end
        end else if (typ == 2'b11 && id == cid) begin
            p.rd = 1'b1;
            r = w;
            r[25:18] = mm[p.addr];
            r[62] = 1'b1;
            r[9:2] = cid;
            p.tx = 1'b1;
            p.txd = addpar(r);
        end else if (typ == 2'b11 && id == 8'hFF) begin
            p.tx = 1'b0;
        end else begin
            p.tx = 1'b1;
            p.txd = addpar(w);
        end
        return p;
    endfunction

    // uart_rx stand-in, config regfile and random ready generator
    always @(posedge clk) begin
        cyc <= cyc + 1;
        rdy_rand <= ($urandom_range(0, 3) != 0);
        if (rx_full && uld_rx_data) begin
            rx_full <= 1'b0;
        end else if (!rx_full && rxq.size() > 0) begin
            rx_data <= rxq[0].w;
            parity_error <= rxq[0].pe;
            rxq.pop_front();
            rx_full <= 1'b1;
            load_edge <= cyc + 1;
        end
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (cfg_wr_en) begin
            mem[cfg_addr] <= cfg_wr_data;
        end
    end

    logic [15:0] sb_e16;
    logic [7:0]  sb_e8;
    logic [63:0] sb_e64;

    // Event counters and scoreboard comparison
    always @(negedge clk) begin
        if (uld_rx_data) n_uld++;
        if (cfg_wr_en) n_wr++;
        if (cfg_rd_en) n_rd++;
        if (tx_valid) n_txv++;
        if (tx_valid && tx_ready) n_acc++;
        if (sb_on) begin
            if (cfg_wr_en) begin
                chk("sb_wr_pending", 64'(exp_wr_q.size() > 0), 64'(1));
                if (exp_wr_q.size() > 0) begin
                    sb_e16 = exp_wr_q.pop_front();
                    chk("sb_wr", 64'({cfg_addr, cfg_wr_data}), 64'(sb_e16));
                end
            end
            if (cfg_rd_en) begin
                chk("sb_rd_pending", 64'(exp_rd_q.size() > 0), 64'(1));
                if (exp_rd_q.size() > 0) begin
                    sb_e8 = exp_rd_q.pop_front();
                    chk("sb_rd", 64'(cfg_addr), 64'(sb_e8));
                end
            end
            if (tx_valid && tx_ready) begin
                chk("sb_tx_pending", 64'(exp_tx_q.size() > 0), 64'(1));
                if (exp_tx_q.size() > 0) begin
                    sb_e64 = exp_tx_q.pop_front();
                    chk("sb_tx", tx_data, sb_e64);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t        vt[12];
    pred_t       pr;
    int          fw, fr, ft, nu, t, b_uld, b_txv, b_acc;
    logic [7:0]  wa, wd, ra;
    logic [63:0] td, r64;
    logic [62:0] w1, w2, wr_;
    logic        pe_;
    logic [1:0]  typ_;

    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 8'(i) ^ 8'h5A;

        vt[0]  = '{mk(2'd2, 8'h05, 8'h12, 8'hA5, 37'h0ABCDE), 1'b0, 8'h05,
                   1'b1, 1'b0, 1'b0, 8'h12, 8'hA5, 63'h0};
        vt[1]  = '{mk(2'd2, 8'h05, 8'h07, 8'h3C, 37'h1), 1'b0, 8'h05,
                   1'b1, 1'b0, 1'b0, 8'h07, 8'h3C, 63'h0};
        vt[2]  = '{mk(2'd3, 8'h05, 8'h07, 8'h00, 37'h0_1234_5678), 1'b0, 8'h05,
                   1'b0, 1'b1, 1'b1, 8'h07, 8'h00,
                   mk(2'd3, 8'h05, 8'h07, 8'h3C, 37'h10_1234_5678)};
        vt[3]  = '{mk(2'd0, 8'h09, 8'h44, 8'h55, 37'h155), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
                   mk(2'd0, 8'h09, 8'h44, 8'h55, 37'h155)};
        vt[4]  = '{mk(2'd2, 8'hFF, 8'h20, 8'h5A, 37'h77), 1'b0, 8'h05,
                   1'b1, 1'b0, 1'b1, 8'h20, 8'h5A,
                   mk(2'd2, 8'hFF, 8'h20, 8'h5A, 37'h77)};
        vt[5]  = '{mk(2'd3, 8'hFF, 8'h20, 8'h00, 37'h0), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 63'h0};
        vt[6]  = '{mk(2'd1, 8'h05, 8'h01, 8'h02, 37'h1F0F0F0F0), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
                   mk(2'd1, 8'h05, 8'h01, 8'h02, 37'h1F0F0F0F0)};
        vt[7]  = '{mk(2'd2, 8'h33, 8'h11, 8'h22, 37'h3), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
                   mk(2'd2, 8'h33, 8'h11, 8'h22, 37'h3)};
        vt[8]  = '{mk(2'd3, 8'h33, 8'h11, 8'h00, 37'h4), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
                   mk(2'd3, 8'h33, 8'h11, 8'h00, 37'h4)};
        vt[9]  = '{mk(2'd2, 8'h05, 8'h30, 8'h99, 37'h5), 1'b1, 8'h05,
                   1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 63'h0};
        vt[10] = '{mk(2'd3, 8'hFF, 8'h20, 8'h00, 37'h3), 1'b0, 8'hFF,
                   1'b0, 1'b1, 1'b1, 8'h20, 8'h00,
                   mk(2'd3, 8'hFF, 8'h20, 8'h5A, 37'h10_0000_0003)};
        vt[11] = '{mk(2'd0, 8'h05, 8'h66, 8'h77, 37'h10_0000_00AB), 1'b0, 8'h05,
                   1'b0, 1'b0, 1'b1, 8'h00, 8'h00,
                   mk(2'd0, 8'h05, 8'h66, 8'h77, 37'h10_0000_00AB)};

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uld", 64'(uld_rx_data), 64'(0));
        chk("rst_wr", 64'(cfg_wr_en), 64'(0));
        chk("rst_rd", 64'(cfg_rd_en), 64'(0));
        chk("rst_addr", 64'(cfg_addr), 64'(0));
        chk("rst_wdata", 64'(cfg_wr_data), 64'(0));
        chk("rst_txd", tx_data, 64'(0));
        chk("rst_txv", 64'(tx_valid), 64'(0));
        chk("rst_pcnt", 64'(parity_err_cnt), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_man = 1'b1;

        // directed vector table
        for (int i = 0; i < 12; i++) begin
            chip_id = vt[i].cid;
            fw = -1; fr = -1; ft = -1; nu = 0;
            wa = '0; wd = '0; ra = '0; td = '0;
            rxq.push_back('{vt[i].w, vt[i].pe});
            repeat (12) begin
                @(negedge clk);
                if (uld_rx_data) nu++;
                if (cfg_wr_en && fw < 0) begin
                    fw = cyc - load_edge; wa = cfg_addr; wd = cfg_wr_data;
                end
                if (cfg_rd_en && fr < 0) begin
                    fr = cyc - load_edge; ra = cfg_addr;
                end
                if (tx_valid && ft < 0) begin
                    ft = cyc - load_edge; td = tx_data;
                end
            end
            chk($sformatf("vec%0d_uld", i), 64'(nu), 64'(1));
            chk($sformatf("vec%0d_wr_seen", i), 64'(fw >= 0), 64'(vt[i].ewr));
            chk($sformatf("vec%0d_rd_seen", i), 64'(fr >= 0), 64'(vt[i].erd));
            chk($sformatf("vec%0d_tx_seen", i), 64'(ft >= 0), 64'(vt[i].etx));
            if (vt[i].ewr) begin
                chk($sformatf("vec%0d_wr_lat", i), 64'(fw), 64'(4));
                chk($sformatf("vec%0d_wr_addr", i), 64'(wa), 64'(vt[i].eaddr));
                chk($sformatf("vec%0d_wr_data", i), 64'(wd), 64'(vt[i].ewd));
                mm[vt[i].eaddr] = vt[i].ewd;
            end
            if (vt[i].erd) begin
                chk($sformatf("vec%0d_rd_lat", i), 64'(fr), 64'(4));
                chk($sformatf("vec%0d_rd_addr", i), 64'(ra), 64'(vt[i].eaddr));
            end
            if (vt[i].etx) begin
                chk($sformatf("vec%0d_tx_lat", i), 64'(ft), vt[i].erd ? 64'(5) : 64'(4));
                chk($sformatf("vec%0d_tx_data", i), td, addpar(vt[i].etx63));
            end
            if (vt[i].pe) pcnt_model++;
            @(posedge clk);
            #1;
        end
        chk("tbl_pcnt", 64'(parity_err_cnt), 64'(pcnt_model));

        // forward with backpressure while a second word waits
        chip_id = 8'h05;
        rdy_man = 1'b0;
        w1 = mk(2'd0, 8'h09, 8'h13, 8'h57, 37'h0_DEAD_BEEF);
        w2 = mk(2'd2, 8'h05, 8'h40, 8'hC3, 37'h9);
        rxq.push_back('{w1, 1'b0});
        rxq.push_back('{w2, 1'b0});
        t = 0;
        while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_valid", 64'(tx_valid), 64'(1));
        repeat (2) @(negedge clk);
        b_uld = n_uld;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), {63'(0), tx_valid} ^ 64'(1) | (tx_data ^ addpar(w1)), 64'(0));
        end
        @(posedge clk);
        #1;
        chk("bp_no_uld", 64'(n_uld - b_uld), 64'(0));
        chk("bp_pending", 64'(rx_empty), 64'(0));
        b_uld = n_uld;
        b_acc = n_acc;
        rdy_man = 1'b1;
        t = 0;
        while (!cfg_wr_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("bp_wr2", 64'({cfg_wr_en, cfg_addr, cfg_wr_data}), 64'({1'b1, 8'h40, 8'hC3}));
        mm[8'h40] = 8'hC3;
        @(posedge clk);
        #1;
        chk("bp_acc", 64'(n_acc - b_acc), 64'(1));
        chk("bp_uld2", 64'(n_uld - b_uld), 64'(1));

        // parity errors saturate the counter and produce nothing else
        b_uld = n_wr + n_rd;
        b_txv = n_txv;
        for (int k = 0; k < 260; k++) begin
            wr_ = 63'({$urandom(), $urandom()});
            pr = predict(wr_, 1'b1, chip_id);
            rxq.push_back('{wr_, 1'b1});
        end
        t = 0;
        while ((rxq.size() != 0 || rx_full) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        chk("perr_drain", 64'(t < 3000), 64'(1));
        repeat (10) @(posedge clk);
        #1;
        chk("perr_no_cfg", 64'(n_wr + n_rd - b_uld), 64'(0));
        chk("perr_no_tx", 64'(n_txv - b_txv), 64'(0));
        chk("perr_sat", 64'(parity_err_cnt), 64'(pcnt_model));
        chk("perr_sat255", 64'(parity_err_cnt), 64'(255));

        // reset while holding a packet in SEND
        rdy_man = 1'b0;
        b_acc = n_acc;
        w1 = mk(2'd0, 8'h22, 8'h01, 8'h01, 37'h1234);
        w2 = mk(2'd2, 8'h05, 8'h50, 8'hE7, 37'h2);
        rxq.push_back('{w1, 1'b0});
        rxq.push_back('{w2, 1'b0});
        t = 0;
        while (!tx_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rs_valid", 64'(tx_valid), 64'(1));
        repeat (2) @(negedge clk);
        chk("rs_pending", 64'(rx_empty), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rs_txv", 64'(tx_valid), 64'(0));
        chk("rs_txd", tx_data, 64'(0));
        chk("rs_pcnt", 64'(parity_err_cnt), 64'(0));
        chk("rs_cfg", 64'({uld_rx_data, cfg_wr_en, cfg_rd_en, cfg_addr, cfg_wr_data}), 64'(0));
        pcnt_model = 0;
        reset = 1'b0;
        rdy_man = 1'b1;
        t = 0;
        while (!cfg_wr_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rs_wr_after", 64'({cfg_wr_en, cfg_addr, cfg_wr_data}), 64'({1'b1, 8'h50, 8'hE7}));
        mm[8'h50] = 8'hE7;
        @(posedge clk);
        #1;
        chk("rs_no_acc", 64'(n_acc - b_acc), 64'(0));

        // reset while in CLEAR
        b_txv = n_txv;
        w1 = mk(2'd0, 8'h23, 8'h02, 8'h03, 37'h55);
        w2 = mk(2'd2, 8'h05, 8'h51, 8'h1E, 37'h6);
        rxq.push_back('{w1, 1'b0});
        rxq.push_back('{w2, 1'b0});
        t = 0;
        while (!uld_rx_data && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rc_uld", 64'(uld_rx_data), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rc_out0", 64'({uld_rx_data, tx_valid, cfg_wr_en}), 64'(0));
        t = 0;
        while (!cfg_wr_en && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("rc_wr_after", 64'({cfg_wr_en, cfg_addr, cfg_wr_data}), 64'({1'b1, 8'h51, 8'h1E}));
        mm[8'h51] = 8'h1E;
        repeat (10) @(posedge clk);
        #1;
        chk("rc_no_tx", 64'(n_txv - b_txv), 64'(0));

        // random traffic against the reference model
        chip_id = 8'($urandom_range(0, 254));
        rand_mode = 1'b1;
        sb_on = 1'b1;
        for (int k = 0; k < 300; k++) begin
            r64 = {$urandom(), $urandom()};
            wr_ = r64[62:0];
            typ_ = 2'($urandom_range(0, 3));
            wr_[1:0] = typ_;
            case ($urandom_range(0, 3))
                0, 3: wr_[9:2] = chip_id;
                1: wr_[9:2] = 8'hFF;
                default: wr_[9:2] = 8'($urandom());
            endcase
            pe_ = ($urandom_range(0, 9) == 0);
            pr = predict(wr_, pe_, chip_id);
            if (pr.wr) exp_wr_q.push_back({pr.addr, pr.wd});
            if (pr.rd) exp_rd_q.push_back(pr.addr);
            if (pr.tx) exp_tx_q.push_back(pr.txd);
            rxq.push_back('{wr_, pe_});
        end
        t = 0;
        while ((rxq.size() != 0 || rx_full || exp_wr_q.size() != 0 ||
                exp_rd_q.size() != 0 || exp_tx_q.size() != 0) && t < 10000) begin
            @(posedge clk);
            t++;
        end
        chk("rand_drain", 64'(t < 10000), 64'(1));
        repeat (20) @(posedge clk);
        #1;
        chk("rand_left", 64'(exp_wr_q.size() + exp_rd_q.size() + exp_tx_q.size()), 64'(0));
        chk("rand_pcnt", 64'(parity_err_cnt), 64'(pcnt_model));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
